// File: rtl/sm_clk_ctrl_pkg.sv
// Shared mode codes and FSM state encodings for the CPU clock-control unit.
package sm_clk_ctrl_pkg;

  // Mode selector codes, also used by the board wrapper.
  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  // Strobe generator states; STEP is handled inside IDLE since it is a single pulse.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_BURST = 2'b10
  } state_t;

endpackage

// File: rtl/sm_clk_ctrl_debouncer.sv
// Step-key conditioning: 2-FF synchroniser, stability counter and rising-edge pulse.
module sm_debouncer
  import sm_clk_ctrl_pkg::*;
#(
  parameter int DBNC_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic rise
);

  logic              sync1_reg;
  logic              sync2_reg;
  logic              level_reg;
  logic [DBNC_W-1:0] cnt_reg;

  // Bring the asynchronous key into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= key;
      sync2_reg <= sync1_reg;
    end
  end

  // Accept a new level only after it has differed for a full counter span; pulse on 0->1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise      <= 1'b0;
    end else if (sync2_reg == level_reg) begin
      cnt_reg <= '0;
      rise    <= 1'b0;
    end else if (&cnt_reg) begin
      cnt_reg   <= '0;
      level_reg <= sync2_reg;
      rise      <= sync2_reg;
    end else begin
      cnt_reg <= cnt_reg + DBNC_W'(1);
      rise    <= 1'b0;
    end
  end

endmodule

// File: rtl/sm_clk_ctrl.sv
// CPU clock-enable generator: runtime divider, HALT/RUN/STEP/BURST FSM, strobe counter.
module sm_clk_ctrl
  import sm_clk_ctrl_pkg::*;
#(
  parameter int DIV_W   = 26,
  parameter int DBNC_W  = 16,
  parameter int BURST_W = 8,
  parameter int CNT_W   = 32
) (
  input  logic               clkIn,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   div,
  input  logic [BURST_W-1:0] burstLen,
  input  logic               stepKey,
  output logic               cpuEn,
  output logic               busy,
  output logic [CNT_W-1:0]   cycleCnt
);

  state_t             state_reg, state_next;
  logic [DIV_W-1:0]   div_cnt_reg, div_cnt_next;
  logic [BURST_W-1:0] remain_reg, remain_next;
  logic               cpu_en_reg, cpu_en_next;
  logic               busy_reg, busy_next;
  logic [CNT_W-1:0]   cycle_cnt_reg;
  logic               step_req;
  logic               tick;
  logic               last_strobe;

  sm_debouncer #(
    .DBNC_W (DBNC_W)
  ) u_debouncer (
    .clk   (clkIn),
    .rst_n (rst_n),
    .key   (stepKey),
    .rise  (step_req)
  );

  // div is compared live, so lowering it below the running count fires at once.
  assign tick = (div_cnt_reg >= div);

  // State, divider, burst and output registers.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      div_cnt_reg <= '0;
      remain_reg  <= '0;
      cpu_en_reg  <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      div_cnt_reg <= div_cnt_next;
      remain_reg  <= remain_next;
      cpu_en_reg  <= cpu_en_next;
      busy_reg    <= busy_next;
    end
  end

  // Next-state logic; leaving RUN or BURST takes priority over any strobe that cycle.
  always_comb begin
    state_next   = state_reg;
    div_cnt_next = div_cnt_reg;
    remain_next  = remain_reg;
    cpu_en_next  = 1'b0;
    last_strobe  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (mode == MODE_RUN) begin
          state_next = ST_RUN;
        end else if (step_req && mode == MODE_STEP) begin
          cpu_en_next = 1'b1;
        end else if (step_req && mode == MODE_BURST && burstLen != '0) begin
          remain_next  = burstLen;
          div_cnt_next = '0;
          state_next   = ST_BURST;
        end
      end
      ST_RUN: begin
        if (mode != MODE_RUN) begin
          state_next   = ST_IDLE;
          div_cnt_next = '0;
        end else if (tick) begin
          cpu_en_next  = 1'b1;
          div_cnt_next = '0;
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end
      ST_BURST: begin
        if (mode != MODE_BURST) begin
          state_next   = ST_IDLE;
          div_cnt_next = '0;
        end else if (tick) begin
          cpu_en_next  = 1'b1;
          div_cnt_next = '0;
          remain_next  = remain_reg - BURST_W'(1);
          if (remain_reg == BURST_W'(1)) begin
            state_next  = ST_IDLE;
            last_strobe = 1'b1;
          end
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end
      default: begin
        state_next   = ST_IDLE;
        div_cnt_next = '0;
      end
    endcase
    // Keep busy up through the final strobe so it drops the cycle after it.
    busy_next = (state_next == ST_BURST) || last_strobe;
  end

  // Count issued strobes; wraps naturally.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_reg <= '0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(cpu_en_reg);
    end
  end

  assign cpuEn    = cpu_en_reg;
  assign busy     = busy_reg;
  assign cycleCnt = cycle_cnt_reg;

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Self-checking bench for sm_clk_ctrl: cycle model plus directed literal checks and random stimulus.
module tb_sm_clk_ctrl;

  localparam int DIV_W   = 8;
  localparam int DBNC_W  = 3;
  localparam int BURST_W = 8;
  localparam int CNT_W   = 4;
  localparam int DBNC_N  = 1 << DBNC_W;
  localparam int CNT_MOD = 1 << CNT_W;

  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_BURST = 2;

  logic               clkIn = 1'b0;
  logic               rst_n;
  logic [1:0]         mode;
  logic [DIV_W-1:0]   div;
  logic [BURST_W-1:0] burstLen;
  logic               stepKey;
  logic               cpuEn;
  logic               busy;
  logic [CNT_W-1:0]   cycleCnt;

  int checks = 0;
  int errors = 0;
  int cmp_checks = 0;
  int cmp_errors = 0;
  int en_total = 0;
  int dbl_total = 0;
  int en_busy_total = 0;
  bit prev_en = 1'b0;

  sm_clk_ctrl #(
    .DIV_W   (DIV_W),
    .DBNC_W  (DBNC_W),
    .BURST_W (BURST_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clkIn    (clkIn),
    .rst_n    (rst_n),
    .mode     (mode),
    .div      (div),
    .burstLen (burstLen),
    .stepKey  (stepKey),
    .cpuEn    (cpuEn),
    .busy     (busy),
    .cycleCnt (cycleCnt)
  );

  always #5 clkIn = ~clkIn;

  // Behavioural model: key delay line, debounce run length, and strobe scheduling by elapsed cycles.
  bit m_kd0, m_kd1, m_level, m_req, m_en, m_busy, next_req, new_en, last, tick_now;
  int m_run, m_phase, m_elapsed, m_remain, m_cnt;

  always @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      m_kd0 = 0; m_kd1 = 0; m_level = 0; m_req = 0; m_en = 0; m_busy = 0;
      m_run = 0; m_phase = PH_IDLE; m_elapsed = 0; m_remain = 0; m_cnt = 0;
    end else begin
      next_req = 0;
      if (m_kd1 != m_level) begin
        m_run++;
        if (m_run == DBNC_N) begin
          m_level  = m_kd1;
          m_run    = 0;
          next_req = m_level;
        end
      end else begin
        m_run = 0;
      end
      m_kd1 = m_kd0;
      m_kd0 = stepKey;

      m_cnt    = (m_cnt + int'(m_en)) % CNT_MOD;
      new_en   = 0;
      last     = 0;
      tick_now = (m_elapsed >= int'(div));
      case (m_phase)
        PH_IDLE: begin
          if (mode == 2'b01) m_phase = PH_RUN;
          else if (m_req && mode == 2'b10) new_en = 1;
          else if (m_req && mode == 2'b11 && burstLen != 0) begin
            m_remain  = int'(burstLen);
            m_elapsed = 0;
            m_phase   = PH_BURST;
          end
        end
        PH_RUN: begin
          if (mode != 2'b01) begin m_phase = PH_IDLE; m_elapsed = 0; end
          else if (tick_now) begin new_en = 1; m_elapsed = 0; end
          else m_elapsed++;
        end
        default: begin
          if (mode != 2'b11) begin m_phase = PH_IDLE; m_elapsed = 0; end
          else if (tick_now) begin
            new_en = 1;
            m_elapsed = 0;
            m_remain--;
            if (m_remain == 0) begin m_phase = PH_IDLE; last = 1; end
          end else m_elapsed++;
        end
      endcase
      m_en   = new_en;
      m_busy = (m_phase == PH_BURST) || last;
      m_req  = next_req;
    end
  end

  // Per-cycle comparison against the model, plus strobe statistics for directed checks.
  always @(negedge clkIn) begin
    cmp_checks++;
    if (cpuEn !== m_en || busy !== m_busy || cycleCnt !== CNT_W'(m_cnt)) begin
      cmp_errors++;
      $display("FAIL cycle_model t=%0t: cpuEn=%b busy=%b cycleCnt=%0d, expected %b %b %0d",
               $time, cpuEn, busy, cycleCnt, m_en, m_busy, m_cnt);
    end
    if (cpuEn === 1'b1) begin
      en_total++;
      if (prev_en) dbl_total++;
      if (busy === 1'b1) en_busy_total++;
    end
    prev_en = (cpuEn === 1'b1);
  end

  task automatic lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clkIn);
    #1;
  endtask

  task automatic press(input int n);
    stepKey = 1'b1;
    cyc(n);
    stepKey = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input int budget, input string name);
    int k = 0;
    while (busy !== val && k < budget) begin
      @(negedge clkIn);
      k++;
    end
    lit(name, int'(busy), int'(val));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int s0, b0, d0, c0, k;
    rst_n = 1'b0; mode = 2'b00; div = '0; burstLen = '0; stepKey = 1'b0;
    #12;
    lit("reset_cpuEn", int'(cpuEn), 0);
    lit("reset_busy", int'(busy), 0);
    lit("reset_cycleCnt", int'(cycleCnt), 0);
    cyc(2);
    rst_n = 1'b1;

    // RUN at div=3: period 4, single-cycle pulses.
    div = 3; mode = 2'b01;
    cyc(8);
    s0 = en_total; d0 = dbl_total; c0 = int'(cycleCnt);
    cyc(40);
    lit("run_div3_strobes", en_total - s0, 10);
    lit("run_div3_width", dbl_total - d0, 0);
    lit("run_div3_cyclecnt", (int'(cycleCnt) - c0 + CNT_MOD) % CNT_MOD, 10);

    // RUN at div=0 strobes every cycle; HALT stops it.
    div = 0;
    cyc(3);
    s0 = en_total;
    cyc(10);
    lit("run_div0_strobes", en_total - s0, 10);
    mode = 2'b00;
    cyc(2);
    s0 = en_total;
    cyc(10);
    lit("halt_strobes", en_total - s0, 0);

    // STEP: short glitches are ignored, a clean press yields one pulse, release none.
    mode = 2'b10;
    cyc(2);
    s0 = en_total;
    press(3); cyc(15); press(5); cyc(15);
    lit("step_glitches", en_total - s0, 0);
    s0 = en_total; d0 = dbl_total;
    press(20); cyc(25);
    lit("step_press", en_total - s0, 1);
    lit("step_width", dbl_total - d0, 0);

    // BURST of 5 at div=1.
    mode = 2'b11; burstLen = 5; div = 1;
    cyc(2);
    s0 = en_total; b0 = en_busy_total; d0 = dbl_total; c0 = int'(cycleCnt);
    press(12); cyc(30);
    lit("burst5_strobes", en_total - s0, 5);
    lit("burst5_busy_at_strobes", en_busy_total - b0, 5);
    lit("burst5_spacing", dbl_total - d0, 0);
    lit("burst5_busy_after", int'(busy), 0);
    lit("burst5_cyclecnt", (int'(cycleCnt) - c0 + CNT_MOD) % CNT_MOD, 5);

    // A second press during a burst neither re-triggers nor queues.
    burstLen = 20;
    s0 = en_total;
    press(10); cyc(12); press(10); cyc(50);
    lit("burst_retrigger", en_total - s0, 20);

    // Long burst aborted by switching to RUN after 3 strobes.
    burstLen = 200; div = 2;
    s0 = en_total;
    press(12);
    k = 0;
    while (en_total - s0 < 3 && k < 100) begin
      @(negedge clkIn);
      k++;
    end
    mode = 2'b01;
    @(negedge clkIn);
    @(negedge clkIn);
    lit("abort_strobes", en_total - s0, 3);
    lit("abort_busy", int'(busy), 0);
    cyc(6);
    s0 = en_total;
    cyc(30);
    lit("abort_run_strobes", en_total - s0, 10);

    // Asynchronous reset mid-burst, then a fresh 17-strobe burst wraps the 4-bit counter.
    mode = 2'b11; burstLen = 200; div = 2;
    cyc(2);
    press(12);
    wait_busy(1'b1, 40, "burst_start_busy");
    cyc(12);
    @(posedge clkIn);
    #3 rst_n = 1'b0;
    #1;
    lit("async_reset_cpuEn", int'(cpuEn), 0);
    lit("async_reset_busy", int'(busy), 0);
    lit("async_reset_cycleCnt", int'(cycleCnt), 0);
    cyc(3);
    rst_n = 1'b1;
    burstLen = 17; div = 0;
    cyc(2);
    lit("post_reset_idle", int'(busy), 0);
    press(12);
    wait_busy(1'b1, 40, "fresh_burst_busy");
    wait_busy(1'b0, 60, "fresh_burst_done");
    cyc(2);
    lit("cyclecnt_wrap", int'(cycleCnt), 1);

    // Random mode/div/length/key activity checked by the model every cycle.
    for (int i = 0; i < 250; i++) begin
      mode     = 2'($urandom_range(0, 3));
      div      = DIV_W'($urandom_range(0, 3));
      burstLen = BURST_W'($urandom_range(0, 6));
      stepKey  = 1'($urandom_range(0, 1));
      cyc($urandom_range(1, 14));
    end
    cyc(2);

    checks += cmp_checks;
    errors += cmp_errors;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
